shift_rotate_unit: RTL and testbench
====================================

// Module: shift_rotate_unit
// PURPOSE
//  Parametrised, multi-cycle shift/rotate unit for the ALU datapath. Supports SHR, SHRA, SHL, ROR and ROL
//  with carry and zero flags. Moves at most STEP bit positions per clock and uses a valid/ready handshake
//  on both sides. Replaces the single-cycle 32-bit rotator where barrel-shift area/timing is too costly.
// PARAMETERS
//  WIDTH  32  operand/result width; power of two, >= 8
//  STEP   4   max bit positions moved per BUSY cycle; power of two, 1..WIDTH
// PORTS
//  clk        in   1      clock, all state updates on rising edge
//  reset_n    in   1      synchronous active-low reset
//  in_valid   in   1      request valid
//  in_ready   out  1      unit can accept a request (IDLE only)
//  op         in   3      000 SHR, 001 SHRA, 010 SHL, 011 ROR, 100 ROL, others illegal
//  a          in   WIDTH  operand
//  amt        in   WIDTH  shift/rotate amount, unsigned
//  out_valid  out  1      result/flags valid (DONE only)
//  out_ready  in   1      consumer takes result
//  result     out  WIDTH  shifted/rotated value
//  carry      out  1      last bit moved out (shift) or wrapped (rotate); 0 if effective amount is 0
//  zero       out  1      result == 0
//  op_err     out  1      request carried an illegal op
//  busy       out  1      state != IDLE
// BEHAVIOUR
//  Reset: when reset_n=0 at a clock edge, state=IDLE. result, carry, zero, op_err, out_valid, busy = 0;
//   in_ready = 1 from the first edge with reset_n=1. Reset wins over every other event, including mid-BUSY
//   and DONE; any in-flight request is discarded with no output.
//  Accept: in_valid & in_ready at an edge latch a, op and amt.
//   Effective amount eff: rotates use amt mod WIDTH (low log2(WIDTH) bits).
//   Shifts use min(amt, WIDTH), compared over the full amt width.
//  FSM: IDLE -> BUSY if eff != 0. IDLE -> DONE if eff == 0 or op is illegal.
//   BUSY: each cycle moves k = min(STEP, remaining) positions and sets remaining -= k.
//   BUSY -> DONE on the cycle remaining reaches 0.
//   DONE: out_valid=1; result/flags stable. DONE -> IDLE at an edge with out_ready=1.
//   No accept in the same cycle as the DONE handshake; in_ready rises the following cycle.
//  Latency: out_valid asserts ceil(eff/STEP)+1 cycles after the accept edge. eff=0 or illegal op -> 1 cycle.
//  Fill rules: SHR/SHL fill with 0; SHRA fills with a[WIDTH-1]. ROR/ROL bits leaving one end enter the other.
//  Shift by WIDTH: SHR/SHL -> 0; SHRA -> all copies of the sign bit.
//  Carry: the bit that left the operand on the final single-position move.
//   SHL: a[WIDTH-eff]. SHR/SHRA: a[eff-1]. ROR: result[WIDTH-1]. ROL: result[0].
//  Zero: computed from the final result, valid with out_valid.
//  Illegal op: result=a, carry=0, zero=(a==0), op_err=1. op_err clears on the next accept.
//  Backpressure: while out_valid & !out_ready, result/carry/zero/op_err hold, and in_ready=0.
//  In IDLE/BUSY outputs keep their last DONE values; out_valid=0.
//  Internal remaining counter is log2(WIDTH)+1 bits, so eff=WIDTH is representable.
// TESTING (WIDTH=32, STEP=4 unless stated)
//  1. ROR a=0x000000F1 amt=4 -> result 0x1000000F, carry 0, zero 0; out_valid 2 cycles after accept.
//  2. SHRA a=0x80000000 amt=40 -> eff 32, result 0xFFFFFFFF, carry 1; out_valid 9 cycles after accept.
//  3. SHL a=0x00000001 amt=31 -> 0x80000000, carry 0.
//     SHL a=0x00000001 amt=32 -> 0x00000000, carry 1, zero 1.
//  4. ROL a=0x80000001 amt=33 -> eff 1, 0x00000003, carry 1.
//     ROR amt=0 -> result=a, carry 0, 1-cycle latency.
//     op=111 -> result=a, op_err=1.
//  5. Hold out_ready=0 for 5 cycles in DONE -> outputs stable, in_ready=0.
//     Release -> IDLE next cycle; back-to-back requests complete in order.
//  6. Assert reset_n=0 mid-BUSY -> next edge IDLE, all outputs 0, no out_valid for the aborted request.
//     Repeat tests 1-4 with STEP=1 and STEP=32; latency must match ceil(eff/STEP)+1.

Source files
------------

// File: rtl/shift_rotate_unit.sv
// Multi-cycle shift/rotate unit: moves at most STEP bit positions per clock.
// Valid/ready handshake on request and result sides, with carry and zero flags.
module shift_rotate_unit #(
    parameter int WIDTH = 32,
    parameter int STEP  = 4
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] amt,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic             carry,
    output logic             zero,
    output logic             op_err,
    output logic             busy
);

    localparam int LW = $clog2(WIDTH);
    localparam int RW = LW + 1;

    localparam logic [2:0] OP_SHR  = 3'b000;
    localparam logic [2:0] OP_SHRA = 3'b001;
    localparam logic [2:0] OP_SHL  = 3'b010;
    localparam logic [2:0] OP_ROR  = 3'b011;
    localparam logic [2:0] OP_ROL  = 3'b100;

    typedef enum logic [1:0] {
        S_IDLE,
        S_BUSY,
        S_DONE
    } state_t;

    state_t           state;
    state_t           state_nx;
    logic [WIDTH-1:0] work;
    logic [2:0]       op_q;
    logic [RW-1:0]    rem;
    logic             ready_q;

    logic             accept;
    logic             legal;
    logic [RW-1:0]    eff;
    logic [RW-1:0]    k;
    logic [WIDTH-1:0] mv;
    logic [WIDTH-1:0] tmp;
    logic             mc;

    assign accept = in_valid & in_ready;
    assign legal  = (op <= OP_ROL);
    assign k      = (rem > RW'(STEP)) ? RW'(STEP) : rem;

    // Effective amount: rotates wrap, shifts saturate at WIDTH; illegal ops move nothing
    always_comb begin
        eff = '0;
        if (!legal)
            eff = '0;
        else if (op == OP_ROR || op == OP_ROL)
            eff = {1'b0, amt[LW-1:0]};
        else if (amt >= WIDTH'(WIDTH))
            eff = RW'(WIDTH);
        else
            eff = amt[RW-1:0];
    end

    // One BUSY step: move k positions and capture the bit from the last single move
    always_comb begin
        mv  = work;
        tmp = '0;
        mc  = 1'b0;
        case (op_q)
            OP_SHR: begin
                mv  = work >> k;
                tmp = work >> (k - RW'(1));
                mc  = tmp[0];
            end
            OP_SHRA: begin
                mv  = $signed(work) >>> k;
                tmp = $signed(work) >>> (k - RW'(1));
                mc  = tmp[0];
            end
            OP_SHL: begin
                mv  = work << k;
                tmp = work << (k - RW'(1));
                mc  = tmp[WIDTH-1];
            end
            OP_ROR: begin
                mv = (work >> k) | (work << (RW'(WIDTH) - k));
                mc = mv[WIDTH-1];
            end
            OP_ROL: begin
                mv = (work << k) | (work >> (RW'(WIDTH) - k));
                mc = mv[0];
            end
            default: begin
                mv = work;
                mc = 1'b0;
            end
        endcase
    end

    // State register
    always_ff @(posedge clk) begin
        if (!reset_n)
            state <= S_IDLE;
        else
            state <= state_nx;
    end

    // Next-state logic
    always_comb begin
        state_nx = state;
        case (state)
            S_IDLE: begin
                if (accept)
                    state_nx = (eff == '0) ? S_DONE : S_BUSY;
            end
            S_BUSY: begin
                if (rem == k)
                    state_nx = S_DONE;
            end
            S_DONE: begin
                if (out_ready)
                    state_nx = S_IDLE;
            end
            default: state_nx = S_IDLE;
        endcase
    end

    // Handshake and status outputs
    always_comb begin
        in_ready  = (state == S_IDLE) && ready_q;
        out_valid = (state == S_DONE);
        busy      = (state != S_IDLE);
    end

    // Ready is held low until the first edge out of reset
    always_ff @(posedge clk) begin
        if (!reset_n)
            ready_q <= 1'b0;
        else
            ready_q <= 1'b1;
    end

    // Datapath: latch request, step the working value, publish result on DONE entry
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            work   <= '0;
            op_q   <= '0;
            rem    <= '0;
            result <= '0;
            carry  <= 1'b0;
            zero   <= 1'b0;
            op_err <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (accept) begin
                        work   <= a;
                        op_q   <= op;
                        rem    <= eff;
                        op_err <= !legal;
                        if (eff == '0) begin
                            result <= a;
                            carry  <= 1'b0;
                            zero   <= (a == '0);
                        end
                    end
                end
                S_BUSY: begin
                    work <= mv;
                    rem  <= rem - k;
                    if (rem == k) begin
                        result <= mv;
                        carry  <= mc;
                        zero   <= (mv == '0);
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_shift_rotate_unit.sv
// Testbench for shift_rotate_unit: three instances (STEP 4, 1, 32) share stimulus.
// Expected results come from a hand-derived vector table through a scoreboard queue.
module tb_shift_rotate_unit;

    typedef struct {
        logic [2:0]  op;
        logic [31:0] a;
        logic [31:0] amt;
        logic [31:0] res;
        logic        c;
        logic        z;
        logic        e;
        int          eff;
    } vec_t;

    localparam int NV = 17;
    localparam int ND = 3;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        in_valid = 1'b0;
    logic        out_ready = 1'b0;
    logic [2:0]  op = 3'b000;
    logic [31:0] a = '0;
    logic [31:0] amt = '0;

    logic        ir [ND];
    logic        ov [ND];
    logic        cy [ND];
    logic        zr [ND];
    logic        oe [ND];
    logic        bz [ND];
    logic [31:0] rs [ND];

    int   steps [ND] = '{4, 1, 32};
    int   checks = 0;
    int   errors = 0;
    vec_t tv [NV];
    vec_t exp_q [$];
    vec_t bb_q [$];

    always #5 clk = ~clk;

    shift_rotate_unit #(.WIDTH(32), .STEP(4)) u4 (
        .clk(clk), .reset_n(reset_n), .in_valid(in_valid), .in_ready(ir[0]),
        .op(op), .a(a), .amt(amt), .out_valid(ov[0]), .out_ready(out_ready),
        .result(rs[0]), .carry(cy[0]), .zero(zr[0]), .op_err(oe[0]), .busy(bz[0])
    );

    shift_rotate_unit #(.WIDTH(32), .STEP(1)) u1 (
        .clk(clk), .reset_n(reset_n), .in_valid(in_valid), .in_ready(ir[1]),
        .op(op), .a(a), .amt(amt), .out_valid(ov[1]), .out_ready(out_ready),
        .result(rs[1]), .carry(cy[1]), .zero(zr[1]), .op_err(oe[1]), .busy(bz[1])
    );

    shift_rotate_unit #(.WIDTH(32), .STEP(32)) u32 (
        .clk(clk), .reset_n(reset_n), .in_valid(in_valid), .in_ready(ir[2]),
        .op(op), .a(a), .amt(amt), .out_valid(ov[2]), .out_ready(out_ready),
        .result(rs[2]), .carry(cy[2]), .zero(zr[2]), .op_err(oe[2]), .busy(bz[2])
    );

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] want);
        checks++;
        if (act !== want) begin
            errors++;
            $display("FAIL %s got %h want %h", nm, act, want);
        end
    endtask

    task automatic wait_all_ready();
        int n = 0;
        while (!(ir[0] && ir[1] && ir[2]) && n < 100) begin
            @(posedge clk);
            #1;
            n++;
        end
        chk("ready_timeout", 32'(n < 100), 32'd1);
    endtask

    task automatic run_vec(input int idx, input bit release_it);
        int   lat [ND];
        int   c;
        bit   all;
        vec_t e;
        wait_all_ready();
        @(negedge clk);
        op       = tv[idx].op;
        a        = tv[idx].a;
        amt      = tv[idx].amt;
        in_valid = 1'b1;
        exp_q.push_back(tv[idx]);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        lat = '{-1, -1, -1};
        c   = 1;
        all = 1'b0;
        while (!all && c <= 60) begin
            all = 1'b1;
            for (int d = 0; d < ND; d++) begin
                if (ov[d] && lat[d] < 0) lat[d] = c;
                if (lat[d] < 0) all = 1'b0;
            end
            if (!all) begin
                @(posedge clk);
                #1;
                c++;
            end
        end
        e = exp_q.pop_front();
        for (int d = 0; d < ND; d++) begin
            int want_lat;
            want_lat = (e.eff == 0) ? 1 : (e.eff + steps[d] - 1) / steps[d] + 1;
            chk($sformatf("v%0d_s%0d_res", idx, steps[d]), rs[d], e.res);
            chk($sformatf("v%0d_s%0d_carry", idx, steps[d]), 32'(cy[d]), 32'(e.c));
            chk($sformatf("v%0d_s%0d_zero", idx, steps[d]), 32'(zr[d]), 32'(e.z));
            chk($sformatf("v%0d_s%0d_err", idx, steps[d]), 32'(oe[d]), 32'(e.e));
            chk($sformatf("v%0d_s%0d_lat", idx, steps[d]), 32'(lat[d]), 32'(want_lat));
        end
        if (release_it) begin
            out_ready = 1'b1;
            @(posedge clk);
            #1;
            out_ready = 1'b0;
        end
    endtask

    initial begin
        tv[0]  = '{3'b011, 32'h000000F1, 32'd4,          32'h1000000F, 1'b0, 1'b0, 1'b0, 4};
        tv[1]  = '{3'b001, 32'h80000000, 32'd40,         32'hFFFFFFFF, 1'b1, 1'b0, 1'b0, 32};
        tv[2]  = '{3'b010, 32'h00000001, 32'd31,         32'h80000000, 1'b0, 1'b0, 1'b0, 31};
        tv[3]  = '{3'b010, 32'h00000001, 32'd32,         32'h00000000, 1'b1, 1'b1, 1'b0, 32};
        tv[4]  = '{3'b100, 32'h80000001, 32'd33,         32'h00000003, 1'b1, 1'b0, 1'b0, 1};
        tv[5]  = '{3'b011, 32'h12345678, 32'd0,          32'h12345678, 1'b0, 1'b0, 1'b0, 0};
        tv[6]  = '{3'b111, 32'hDEADBEEF, 32'd5,          32'hDEADBEEF, 1'b0, 1'b0, 1'b1, 0};
        tv[7]  = '{3'b000, 32'hF0000000, 32'd4,          32'h0F000000, 1'b0, 1'b0, 1'b0, 4};
        tv[8]  = '{3'b000, 32'h80000000, 32'd100,        32'h00000000, 1'b1, 1'b1, 1'b0, 32};
        tv[9]  = '{3'b011, 32'h00000001, 32'd1,          32'h80000000, 1'b1, 1'b0, 1'b0, 1};
        tv[10] = '{3'b001, 32'h7FFFFFFF, 32'd35,         32'h00000000, 1'b0, 1'b1, 1'b0, 32};
        tv[11] = '{3'b010, 32'h0000000F, 32'd30,         32'hC0000000, 1'b1, 1'b0, 1'b0, 30};
        tv[12] = '{3'b100, 32'h12345678, 32'd8,          32'h34567812, 1'b0, 1'b0, 1'b0, 8};
        tv[13] = '{3'b101, 32'h00000000, 32'd3,          32'h00000000, 1'b0, 1'b1, 1'b1, 0};
        tv[14] = '{3'b000, 32'h00000001, 32'd0,          32'h00000001, 1'b0, 1'b0, 1'b0, 0};
        tv[15] = '{3'b011, 32'h000000F1, 32'hFFFFFFE4,   32'h1000000F, 1'b0, 1'b0, 1'b0, 4};
        tv[16] = '{3'b010, 32'h00000001, 32'h80000001,   32'h00000000, 1'b1, 1'b1, 1'b0, 32};

        // reset state
        repeat (3) @(posedge clk);
        #1;
        for (int d = 0; d < ND; d++) begin
            chk($sformatf("rst_s%0d_res", steps[d]), rs[d], 32'h0);
            chk($sformatf("rst_s%0d_flags", steps[d]),
                32'({cy[d], zr[d], oe[d], ov[d], bz[d], ir[d]}), 32'h0);
        end
        @(negedge clk);
        reset_n = 1'b1;
        @(posedge clk);
        #1;
        for (int d = 0; d < ND; d++)
            chk($sformatf("rst_s%0d_ready", steps[d]), 32'(ir[d]), 32'd1);

        // table-driven vectors
        for (int i = 0; i < NV; i++)
            run_vec(i, 1'b1);

        // backpressure: hold DONE for 5 cycles
        run_vec(1, 1'b0);
        for (int i = 0; i < 5; i++) begin
            @(posedge clk);
            #1;
            chk($sformatf("bp%0d_res", i), rs[0], 32'hFFFFFFFF);
            chk($sformatf("bp%0d_hs", i),
                32'({ov[0], ir[0], cy[0], zr[0], oe[0]}), 32'b10100);
        end
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        chk("bp_release", 32'({ov[0], ir[0]}), 32'b01);

        // back-to-back requests with out_ready held high
        out_ready = 1'b1;
        fork
            begin
                int idx [3] = '{0, 2, 4};
                for (int i = 0; i < 3; i++) begin
                    int n = 0;
                    while (!ir[0] && n < 100) begin
                        @(posedge clk);
                        #1;
                        n++;
                    end
                    op       = tv[idx[i]].op;
                    a        = tv[idx[i]].a;
                    amt      = tv[idx[i]].amt;
                    in_valid = 1'b1;
                    bb_q.push_back(tv[idx[i]]);
                    @(posedge clk);
                    #1;
                    in_valid = 1'b0;
                end
            end
            begin
                int   got = 0;
                vec_t e;
                for (int c = 0; c < 300 && got < 3; c++) begin
                    @(negedge clk);
                    if (ov[0]) begin
                        if (bb_q.size() == 0) begin
                            chk("bb_unexpected", 32'd1, 32'd0);
                        end else begin
                            e = bb_q.pop_front();
                            chk($sformatf("bb%0d_res", got), rs[0], e.res);
                            chk($sformatf("bb%0d_carry", got), 32'(cy[0]), 32'(e.c));
                        end
                        got++;
                    end
                end
                chk("bb_count", 32'(got), 32'd3);
            end
        join
        wait_all_ready();
        out_ready = 1'b0;

        // reset in the middle of a long request
        @(negedge clk);
        op       = 3'b001;
        a        = 32'h80000000;
        amt      = 32'd40;
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("mid_busy", 32'({bz[0], ov[0]}), 32'b10);
        chk("mid_keep", rs[0], 32'h00000003);
        @(negedge clk);
        reset_n = 1'b0;
        @(posedge clk);
        #1;
        chk("abort_res", rs[0], 32'h0);
        chk("abort_flags",
            32'({cy[0], zr[0], oe[0], ov[0], bz[0], bz[1], bz[2]}), 32'h0);
        @(negedge clk);
        reset_n = 1'b1;
        begin
            bit saw = 1'b0;
            for (int c = 0; c < 40; c++) begin
                @(posedge clk);
                #1;
                for (int d = 0; d < ND; d++)
                    if (ov[d]) saw = 1'b1;
            end
            chk("abort_no_valid", 32'(saw), 32'd0);
        end
        chk("abort_ready", 32'({ir[0], ir[1], ir[2]}), 32'b111);

        // unit still works after the abort
        run_vec(0, 1'b1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
